// File: rtl/gt_multilane_phase_align.sv
// Multi-lane GT phase alignment sequencer: master lane first, then slaves in order.
// Define GT_PHALIGN_TIMEOUT_EN to compile in the per-step timeout, retry and FAIL logic.
module gt_multilane_phase_align #(
  parameter int NUM_LANES      = 4,
  parameter int PHALIGN_EDGES  = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRIES    = 3,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                 stable_clk_i,
  input  logic                 rst_n_i,
  input  logic                 run_phalignment_i,
  input  logic                 recclkstable_i,
  output logic [NUM_LANES-1:0] dlysreset_o,
  input  logic [NUM_LANES-1:0] dlysresetdone_i,
  input  logic [NUM_LANES-1:0] phaligndone_i,
  output logic [NUM_LANES-1:0] lane_done_o,
  output logic [LW-1:0]        cur_lane_o,
  output logic                 phase_alignment_done_o,
  output logic                 timeout_o
);

  if (NUM_LANES < 1 || NUM_LANES > 16 ||
      PHALIGN_EDGES < 1 || PHALIGN_EDGES > 3 ||
      TIMEOUT_CYCLES < 16 ||
      MAX_RETRIES < 0 || MAX_RETRIES > 7) begin : g_bad_cfg
    $error("gt_multilane_phase_align: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_INIT, S_RST, S_WAIT_RST, S_COUNT,
    S_NEXT, S_DONE, S_FAIL
  } state_t;

  state_t state_q, state_d;

  logic [NUM_LANES-1:0] drd_s1, drd_s2;
  logic [NUM_LANES-1:0] pd_s1, pd_s2, pd_s3;
  logic [NUM_LANES-1:0] pd_rise;
  logic [1:0]           edge_cnt;
  logic                 run_ok;
  logic                 cur_drd;
  logic                 cur_rise;
  logic                 last_lane;
  logic                 tmo;
  logic                 retry_ok;
  logic [NUM_LANES-1:0] cur_oh;

  assign run_ok    = run_phalignment_i & recclkstable_i;
  assign cur_drd   = drd_s2[cur_lane_o];
  assign cur_rise  = pd_rise[cur_lane_o];
  assign last_lane = (cur_lane_o == LW'(NUM_LANES - 1));
  assign cur_oh    = NUM_LANES'(1) << cur_lane_o;

  always_ff @(posedge stable_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drd_s1  <= '0;
      drd_s2  <= '0;
      pd_s1   <= '0;
      pd_s2   <= '0;
      pd_s3   <= '0;
      pd_rise <= '0;
    end else begin
      drd_s1  <= dlysresetdone_i;
      drd_s2  <= drd_s1;
      pd_s1   <= phaligndone_i;
      pd_s2   <= pd_s1;
      pd_s3   <= pd_s2;
      pd_rise <= pd_s2 & ~pd_s3;
    end
  end

`ifdef GT_PHALIGN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] timer;
  logic [2:0]    retries;

  assign tmo      = (timer == TW'(TIMEOUT_CYCLES - 1));
  assign retry_ok = (retries < 3'(MAX_RETRIES));

  always_ff @(posedge stable_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timer     <= '0;
      retries   <= '0;
      timeout_o <= 1'b0;
    end else if (!run_ok) begin
      timer     <= '0;
      retries   <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= (state_d == S_FAIL);
      case (state_q)
        S_INIT: begin
          timer   <= '0;
          retries <= '0;
        end
        S_RST: timer <= '0;
        S_WAIT_RST, S_COUNT: begin
          if (tmo) begin
            timer <= '0;
            if (retry_ok) retries <= retries + 3'd1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_NEXT: retries <= '0;
        default: ;
      endcase
    end
  end
`else
  assign tmo       = 1'b0;
  assign retry_ok  = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge stable_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_INIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:     if (run_ok) state_d = S_RST;
      S_RST:      state_d = S_WAIT_RST;
      S_WAIT_RST: begin
        if (tmo)          state_d = retry_ok ? S_RST : S_FAIL;
        else if (cur_drd) state_d = S_COUNT;
      end
      // a timeout pre-empts any edge landing in the same cycle
      S_COUNT: begin
        if (tmo) state_d = retry_ok ? S_RST : S_FAIL;
        else if (edge_cnt == 2'(PHALIGN_EDGES)) state_d = S_NEXT;
      end
      S_NEXT:     state_d = last_lane ? S_DONE : S_RST;
      S_DONE:     state_d = S_DONE;
      S_FAIL:     state_d = S_FAIL;
      default:    state_d = S_INIT;
    endcase
    if (!run_ok) state_d = S_INIT;
  end

  always_ff @(posedge stable_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cur_lane_o             <= '0;
      edge_cnt               <= '0;
      dlysreset_o            <= '0;
      lane_done_o            <= '0;
      phase_alignment_done_o <= 1'b0;
    end else if (!run_ok) begin
      cur_lane_o             <= '0;
      edge_cnt               <= '0;
      dlysreset_o            <= '0;
      lane_done_o            <= '0;
      phase_alignment_done_o <= 1'b0;
    end else begin
      dlysreset_o <= (state_q == S_RST) ? cur_oh : '0;
      phase_alignment_done_o <= (state_d == S_DONE);
      case (state_q)
        S_INIT: begin
          cur_lane_o <= '0;
          edge_cnt   <= '0;
        end
        S_RST: edge_cnt <= '0;
        S_COUNT: begin
          if (!tmo && cur_rise && edge_cnt != 2'd3)
            edge_cnt <= edge_cnt + 2'd1;
          if (!tmo && edge_cnt == 2'(PHALIGN_EDGES))
            lane_done_o[cur_lane_o] <= 1'b1;
        end
        S_NEXT: if (!last_lane) cur_lane_o <= cur_lane_o + LW'(1);
        default: ;
      endcase
    end
  end

endmodule
